ifid_hazard_ctrl: RTL and testbench
===================================

# ifid_hazard_ctrl

Hazard and sequencing controller for the front end of the 5-stage pipeline. Each cycle it decides whether the PC advances, whether the IF/ID register holds (stall) or clears (flush), and whether ID/EX receives a bubble. Inputs are load-use hazards, taken branches resolved downstream, and instruction-memory readiness. It sits between the hazard sources (ID/EX fields, branch unit, instruction memory) and the PC / IF/ID / ID/EX enables.

## Interface
- FLUSH_CYCLES, 1 — cycles of IF/ID flush per taken branch (≥1); covers redirected-fetch latency
- WAIT_TIMEOUT, 16 — consecutive imem-not-ready cycles before `imem_timeout` sets (≥1)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- idex_mem_read  in  1  instruction in ID/EX is a load
- idex_rd  in  5  destination register of ID/EX instruction
- ifid_rs1, ifid_rs2  in  5 each  source registers decoded from IF/ID instruction
- branch_taken  in  1  taken branch/jump resolved this cycle (one-cycle pulse per branch)
- imem_ready  in  1  instruction memory returns a valid word this cycle
- pc_write  out  1  PC register load enable
- ifid_stall  out  1  hold IF/ID contents
- ifid_flush  out  1  clear IF/ID to zero
- idex_flush  out  1  zero ID/EX control (bubble)
- imem_timeout  out  1  sticky error flag
- stall_cnt, flush_cnt  out  32 each  performance counters (see Configuration)

## Operation
- States: RUN, FLUSH, IMEM_WAIT. Outputs are combinational from state and inputs (Mealy), so control applies in the same cycle.
- Load-use hazard: LU = idex_mem_read && idex_rd != 0 && (idex_rd == ifid_rs1 || idex_rd == ifid_rs2).
- Priority each cycle: branch_taken > (state FLUSH) > LU > !imem_ready > normal.
- branch_taken (any state):
  - pc_write=1, ifid_flush=1, idex_flush=1, ifid_stall=0.
  - Loads the flush counter with FLUSH_CYCLES-1.
  - Next state is FLUSH if the loaded value is ≠ 0, else RUN.
- FLUSH (no new branch):
  - pc_write=1, ifid_flush=1, idex_flush=0; LU and imem_ready are ignored.
  - Counter decrements; on reaching 0 the next state is RUN.
  - A branch during FLUSH reloads the counter.
- LU (RUN or IMEM_WAIT): pc_write=0, ifid_stall=1, idex_flush=1, ifid_flush=0. No state change.
- !imem_ready (no branch, no LU):
  - pc_write=0, ifid_flush=1 (bubble into IF/ID), idex_flush=0.
  - Next state IMEM_WAIT; the wait counter increments, saturating at WAIT_TIMEOUT.
- IMEM_WAIT with imem_ready=1: normal outputs; next state RUN; wait counter cleared.
- Wait counter reaching WAIT_TIMEOUT sets imem_timeout. It clears only on reset.
- Normal: pc_write=1, all others 0.
- ifid_stall and ifid_flush are never asserted together.
- Reset (while high):
  - Outputs forced to pc_write=0, ifid_stall=0, ifid_flush=1, idex_flush=1.
  - Next state RUN; all counters and imem_timeout cleared to 0.
  - Reset mid-FLUSH or mid-IMEM_WAIT abandons the sequence.

## Timing
- Zero-cycle latency from inputs to control outputs; state/counter changes visible the following cycle.
- Load-use inserts exactly one bubble: the load advances to EX/MEM, so LU deasserts the next cycle.
- Taken branch: IF/ID flushed for exactly FLUSH_CYCLES consecutive cycles, beginning in the branch_taken cycle.
- imem_timeout rises in the cycle after the WAIT_TIMEOUT-th consecutive not-ready cycle.
- First cycle after reset deasserts: state RUN, normal outputs if no hazard.

## Configuration
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments by 1 in every cycle with ifid_stall=1.
  - flush_cnt increments by 1 in every cycle with ifid_flush=1, excluding reset cycles.
  - Both wrap at 2^32 and clear on reset.
- Undefined: both ports tied to constant 0; no counter flops synthesized.

## Test plan
- Reset held 2 cycles, released → during reset pc_write=0, ifid_flush=1, idex_flush=1; next cycle pc_write=1, others 0; counters 0.
- idex_mem_read=1, idex_rd=5, ifid_rs2=5 → one cycle of pc_write=0, ifid_stall=1, idex_flush=1; idex_rd=0 with rs1=0 → no stall.
- FLUSH_CYCLES=3, branch_taken pulse → ifid_flush=1 for 3 cycles, idex_flush=1 only in the first; second branch in cycle 2 → flush extends 3 more cycles from it.
- imem_ready=0 for 4 cycles with WAIT_TIMEOUT=16 → pc_write=0, ifid_flush=1 each cycle, then RUN; imem_timeout stays 0. 16 cycles low → imem_timeout=1, stays 1 until reset.
- Simultaneous branch_taken and LU → branch response (pc_write=1, ifid_flush=1, ifid_stall=0); reset asserted mid-FLUSH → RUN next cycle, no residual flush.
- With HAZARD_PERF_CNT_EN: 1 load-use + 1 branch (FLUSH_CYCLES=2) → stall_cnt=1, flush_cnt=2. Without the macro: both read 0.

Source files
------------

// File: rtl/ifid_hazard_ctrl.sv
// ifid_hazard_ctrl: front-end hazard and sequencing controller.
// Decides each cycle whether the PC advances, and whether IF/ID holds or clears.
// It also decides whether ID/EX receives a bubble.
// Hazard sources are load-use, taken branch and instruction-memory not ready.
// Optional feature: define HAZARD_PERF_CNT_EN to build the stall/flush
// performance counters. Without it, both counter ports read constant 0.
module ifid_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        idex_mem_read_i,
  input  logic [4:0]  idex_rd_i,
  input  logic [4:0]  ifid_rs1_i,
  input  logic [4:0]  ifid_rs2_i,
  input  logic        branch_taken_i,
  input  logic        imem_ready_i,
  output logic        pc_write_o,
  output logic        ifid_stall_o,
  output logic        ifid_flush_o,
  output logic        idex_flush_o,
  output logic        imem_timeout_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WW = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_MAX   = WW'(WAIT_TIMEOUT);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    FLUSH     = 2'd1,
    IMEM_WAIT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic          timeout_q, timeout_d;
  logic          load_use;

  assign load_use = idex_mem_read_i && (idex_rd_i != 5'd0) &&
                    ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));

  // Prioritised Mealy decode of control outputs and next state/counters.
  always_comb begin
    // NOTE: every output and _d gets a default first so no path infers a latch.
    pc_write_o   = 1'b1;
    ifid_stall_o = 1'b0;
    ifid_flush_o = 1'b0;
    idex_flush_o = 1'b0;
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    wcnt_d       = wcnt_q;

    if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
      fcnt_d       = FLUSH_LOAD;
      state_d      = (FLUSH_LOAD != '0) ? FLUSH : RUN;
      wcnt_d       = '0;
    end else if (state_q == FLUSH) begin
      // Redirected fetch still in flight: keep clearing IF/ID, ignore LU/imem.
      ifid_flush_o = 1'b1;
      fcnt_d       = fcnt_q - FW'(1);
      if (fcnt_d == '0) state_d = RUN;
    end else if (load_use) begin
      // One bubble into ID/EX while IF/ID and PC hold; the wait count is held too.
      pc_write_o   = 1'b0;
      ifid_stall_o = 1'b1;
      idex_flush_o = 1'b1;
    end else if (!imem_ready_i) begin
      pc_write_o   = 1'b0;
      ifid_flush_o = 1'b1;
      state_d      = IMEM_WAIT;
      if (wcnt_q != WAIT_MAX) wcnt_d = wcnt_q + WW'(1);
    end else begin
      state_d = RUN;
      wcnt_d  = '0;
    end

    timeout_d = timeout_q || (wcnt_d == WAIT_MAX);

    // Reset overrides the decoded controls so the pipeline is drained.
    if (reset_i) begin
      pc_write_o   = 1'b0;
      ifid_stall_o = 1'b0;
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
    end
  end

  // State, sequence counters and sticky timeout flag.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (reset_i) begin
      state_q   <= RUN;
      fcnt_q    <= '0;
      wcnt_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fcnt_q    <= fcnt_d;
      wcnt_q    <= wcnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign imem_timeout_o = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  // Free-running wrap-around counters of stall and flush cycles.
  // Reset cycles are excluded because the reset branch takes precedence.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (ifid_stall_o) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (ifid_flush_o) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Bench for ifid_hazard_ctrl.
// Directed scenarios run first, followed by random cycles.
// Every cycle is compared against a behavioural model built from the hazard rules.
module tb_ifid_hazard_ctrl;

  localparam int FC = 3;
  localparam int WT = 16;

  logic        clk = 1'b0;
  logic        reset, mem_read, bt, rdy;
  logic [4:0]  rd, rs1, rs2;
  logic        pc_write, ifid_stall, ifid_flush, idex_flush, imem_timeout;
  logic [31:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  // Model state: plain integers describing the sequence in progress.
  int  m_flush_left;  // further FLUSH-state cycles still owed after this one
  int  m_waiting;     // 1 while in an imem wait
  int  m_wait_run;    // consecutive not-ready cycles, saturating at WT
  bit  m_timeout;
  int  m_stalls, m_flushes;

  ifid_hazard_ctrl #(.FLUSH_CYCLES(FC), .WAIT_TIMEOUT(WT)) dut (
    .clk_i(clk), .reset_i(reset), .idex_mem_read_i(mem_read), .idex_rd_i(rd),
    .ifid_rs1_i(rs1), .ifid_rs2_i(rs2), .branch_taken_i(bt), .imem_ready_i(rdy),
    .pc_write_o(pc_write), .ifid_stall_o(ifid_stall), .ifid_flush_o(ifid_flush),
    .idex_flush_o(idex_flush), .imem_timeout_o(imem_timeout),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One cycle: drive at negedge, compare mid-cycle, advance the model at posedge.
  task automatic step(input logic r, input logic mr, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic b, input logic ok);
    bit lu, e_pw, e_st, e_if, e_xf;
    reset = r; mem_read = mr; rd = d; rs1 = s1; rs2 = s2; bt = b; rdy = ok;
    #1;
    lu = mr && (d != 0) && (d == s1 || d == s2);
    e_pw = 1; e_st = 0; e_if = 0; e_xf = 0;
    if (r)                     begin e_pw = 0; e_if = 1; e_xf = 1; end
    else if (b)                begin e_if = 1; e_xf = 1; end
    else if (m_flush_left > 0) begin e_if = 1; end
    else if (lu)               begin e_pw = 0; e_st = 1; e_xf = 1; end
    else if (!ok)              begin e_pw = 0; e_if = 1; end
    check("pc_write",   32'(pc_write),   32'(e_pw));
    check("ifid_stall", 32'(ifid_stall), 32'(e_st));
    check("ifid_flush", 32'(ifid_flush), 32'(e_if));
    check("idex_flush", 32'(idex_flush), 32'(e_xf));
    check("stall_and_flush_exclusive", 32'(ifid_stall & ifid_flush), 32'd0);
    check("imem_timeout", 32'(imem_timeout), 32'(m_timeout));
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt", stall_cnt, 32'(m_stalls));
    check("flush_cnt", flush_cnt, 32'(m_flushes));
`else
    check("stall_cnt", stall_cnt, 32'd0);
    check("flush_cnt", flush_cnt, 32'd0);
`endif
    @(posedge clk);
    if (r) begin
      m_flush_left = 0; m_waiting = 0; m_wait_run = 0; m_timeout = 0;
      m_stalls = 0; m_flushes = 0;
    end else begin
      m_stalls  += int'(e_st);
      m_flushes += int'(e_if);
      if (b) begin
        m_flush_left = FC - 1; m_waiting = 0; m_wait_run = 0;
      end else if (m_flush_left > 0) begin
        m_flush_left--;
      end else if (lu) begin
        // hold everything
      end else if (!ok) begin
        m_waiting = 1;
        if (m_wait_run < WT) m_wait_run++;
      end else begin
        m_waiting = 0; m_wait_run = 0;
      end
      if (m_wait_run == WT) m_timeout = 1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    m_flush_left = 0; m_waiting = 0; m_wait_run = 0; m_timeout = 0;
    m_stalls = 0; m_flushes = 0;
    @(negedge clk);

    // Reset held two cycles, then released.
    step(1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    idle(1);

    // Load-use on rs2, then r0 never hazards.
    step(0, 1, 5'd5, 5'd1, 5'd5, 0, 1);
    idle(1);
    step(0, 1, 5'd0, 5'd0, 5'd3, 0, 1);
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt_after_lu", stall_cnt, 32'd1);
`endif

    // Branch: three flush cycles, with a second branch in cycle 2 extending it.
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 1, 5'd7, 5'd7, 5'd0, 0, 0);   // LU and not-ready ignored in FLUSH
    step(0, 0, 0, 0, 0, 1, 1);
    idle(4);
`ifdef HAZARD_PERF_CNT_EN
    check("flush_cnt_after_branches", flush_cnt, 32'd5);
`endif

    // Short imem stall: four cycles then RUN; no timeout.
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0);
    idle(2);
    check("timeout_after_short_wait", 32'(imem_timeout), 32'd0);

    // Long imem stall: WT cycles sets the sticky flag.
    for (int i = 0; i < WT; i++) step(0, 0, 0, 0, 0, 0, 0);
    idle(3);
    check("timeout_sticky", 32'(imem_timeout), 32'd1);

    // Branch and LU together; then reset mid-FLUSH.
    step(0, 1, 5'd9, 5'd9, 5'd9, 1, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    idle(2);
    check("timeout_cleared_by_reset", 32'(imem_timeout), 32'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] a, s1, s2;
      a  = 5'($urandom_range(0, 3));
      s1 = 5'($urandom_range(0, 3));
      s2 = 5'($urandom_range(0, 3));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0), a, s1, s2,
           ($urandom_range(0, 11) == 0), ($urandom_range(0, 9) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
